// File: rtl/y_packer_pkg.sv
// Shared types and constants for the y_packer result-bit packer.
package y_packer_pkg;

    // Fill-side controller states: FILL accepts bits, HOLD parks a closed
    // word until the output slot can take it.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_t;

    // Default packed word width.
    localparam int PACK_WIDTH = 32;

endpackage

// File: rtl/y_packer_if.sv
// Bit-in / word-out handshake bundle for y_packer.
interface y_packer_if
    import y_packer_pkg::*;
#(
    parameter int WIDTH = PACK_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) ();

    logic             in_valid;
    logic             in_ready;
    logic             in_bit;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_len;
    logic [CW-1:0]    out_ones;

    // Packer side.
    modport slave (
        input  in_valid, in_bit, flush, out_ready,
        output in_ready, out_valid, out_data, out_len, out_ones
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_bit, flush, out_ready,
        input  in_ready, out_valid, out_data, out_len, out_ones
    );

endinterface

// File: rtl/y_word_slot.sv
// Output register slice: one packed word with its length and ones count,
// presented on a valid/ready port. Contents only change when the slot is
// empty or being drained, so they stay stable under backpressure.
module y_word_slot
    import y_packer_pkg::*;
#(
    parameter int WIDTH = PACK_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CW-1:0]    load_len,
    input  logic [CW-1:0]    load_ones,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_len,
    output logic [CW-1:0]    out_ones,
    output logic             free_or_draining
);

    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [CW-1:0]    len_p1;
    logic [CW-1:0]    ones_p1;

    // Slot register: load a closed word, or empty the slot after a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            len_p1  <= '0;
            ones_p1 <= '0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= load_data;
            len_p1  <= load_len;
            ones_p1 <= load_ones;
        end else if (vld_p1 && out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign free_or_draining = !vld_p1 || out_ready;
    assign out_valid        = vld_p1;
    assign out_data         = data_p1;
    assign out_len          = len_p1;
    assign out_ones         = ones_p1;

endmodule

// File: rtl/y_packer.sv
// Packs the mux result bit Y[0] LSB-first into WIDTH-bit words. A word
// closes when it is full or on flush; closed words move into a one-entry
// output slot, and a second closed word waits in the fill register (HOLD)
// while the slot is backpressured.
module y_packer
    import y_packer_pkg::*;
#(
    parameter int WIDTH = PACK_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic      clk,
    input  logic      rst,
    y_packer_if.slave bus
);

    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

    packer_state_t    state_q;
    packer_state_t    state_d;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    ones;

    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] shreg_acc;
    logic [CW-1:0]    cnt_acc;
    logic [CW-1:0]    ones_acc;
    logic             close_word;
    logic             load;
    logic             free_or_draining;

    logic             slot_valid;
    logic [WIDTH-1:0] slot_data;
    logic [CW-1:0]    slot_len;
    logic [CW-1:0]    slot_ones;

    // in_ready comes from registered state only, never from out_ready.
    assign in_ready     = (state_q == FILL) && !rst;
    assign bus.in_ready = in_ready;
    assign accept       = bus.in_valid && in_ready;

    // Fill word as it stands after this cycle's accept. Bits above cnt are
    // always zero, so OR-ing the new bit in at position cnt is enough.
    assign shreg_acc = accept ? (shreg | ({{(WIDTH-1){1'b0}}, bus.in_bit} << cnt)) : shreg;
    assign cnt_acc   = cnt  + {{(CW-1){1'b0}}, accept};
    assign ones_acc  = ones + {{(CW-1){1'b0}}, accept && bus.in_bit};

    // A word closes when it fills up, or on flush with at least one bit.
    assign close_word = (state_q == FILL) &&
                        ((cnt_acc == FULL_CNT) || (bus.flush && (cnt_acc != '0)));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and slot load: transfer a closed word when the slot can
    // take it, otherwise park it in HOLD until the next output handshake.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            FILL: begin
                if (close_word) begin
                    if (free_or_draining) begin
                        load = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (free_or_draining) begin
                    load    = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Fill register and counters: cleared on transfer, advanced on accept.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            shreg <= '0;
            cnt   <= '0;
            ones  <= '0;
        end else if (accept) begin
            shreg <= shreg_acc;
            cnt   <= cnt_acc;
            ones  <= ones_acc;
        end
    end

    y_word_slot #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_slot (
        .clk              (clk),
        .rst              (rst),
        .load             (load),
        .load_data        (shreg_acc),
        .load_len         (cnt_acc),
        .load_ones        (ones_acc),
        .out_ready        (bus.out_ready),
        .out_valid        (slot_valid),
        .out_data         (slot_data),
        .out_len          (slot_len),
        .out_ones         (slot_ones),
        .free_or_draining (free_or_draining)
    );

    assign bus.out_valid = slot_valid;
    assign bus.out_data  = slot_data;
    assign bus.out_len   = slot_len;
    assign bus.out_ones  = slot_ones;

endmodule

// File: tb/tb_y_packer.sv
// Self-checking bench for y_packer: directed scenario tasks plus a
// randomized run, all scored against a queue-based word model.
module tb_y_packer;
    import y_packer_pkg::*;

    localparam int WIDTH = PACK_WIDTH;
    localparam int CW    = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    y_packer_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    y_packer #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               len;
        int               ones;
    } word_t;

    word_t exp_q[$];
    bit    model_bits[$];
    word_t sb_w;
    int    hs_count = 0;

    // Reference model, sampled mid-cycle: every accepted bit joins the
    // current word; a word is emitted when it holds WIDTH bits or when flush
    // arrives while the block is accepting and at least one bit is present.
    // Every output handshake must deliver the oldest expected word.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_bits.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                hs_count++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_unexpected_word: got data=%h len=%0d, required no word", bus.out_data, bus.out_len);
                end else begin
                    sb_w = exp_q.pop_front();
                    if (bus.out_data !== sb_w.data || bus.out_len !== CW'(sb_w.len) || bus.out_ones !== CW'(sb_w.ones)) begin
                        n_bad++;
                        $display("FAIL sb_word #%0d: got data=%h len=%0d ones=%0d, required data=%h len=%0d ones=%0d",
                                 hs_count, bus.out_data, bus.out_len, bus.out_ones, sb_w.data, sb_w.len, sb_w.ones);
                    end
                end
            end
            if (bus.in_ready) begin
                if (bus.in_valid) model_bits.push_back(bus.in_bit);
                if (model_bits.size() == WIDTH || (bus.flush && model_bits.size() > 0)) begin
                    sb_w.data = '0;
                    sb_w.len  = model_bits.size();
                    sb_w.ones = 0;
                    for (int i = 0; i < model_bits.size(); i++) begin
                        sb_w.data = sb_w.data | (WIDTH'(model_bits[i]) << i);
                        sb_w.ones += int'(model_bits[i]);
                    end
                    exp_q.push_back(sb_w);
                    model_bits.delete();
                end
            end
        end
    end

    task automatic drive(input logic v, input logic b, input logic f, input logic r);
        bus.in_valid  = v;
        bus.in_bit    = b;
        bus.flush     = f;
        bus.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            n_cmp++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold cycle %0d: in_ready=%b out_valid=%b, required 0 0", i, bus.in_ready, bus.out_valid);
            end
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", bus.in_ready);
        end
        n_cmp++;
        if (bus.out_data !== '0 || bus.out_len !== '0 || bus.out_ones !== '0) begin
            n_bad++;
            $display("FAIL reset_slot: data=%h len=%0d ones=%0d, required 0 0 0", bus.out_data, bus.out_len, bus.out_ones);
        end
    endtask

    task automatic test_full_word();
        bit early = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            drive(1'b1, (i % 2) == 0, 1'b0, 1'b1);
            if (i < WIDTH - 1 && bus.out_valid !== 1'b0) early = 1'b1;
        end
        n_cmp++;
        if (early) begin
            n_bad++;
            $display("FAIL full_early_valid: out_valid seen=1, required 0 before word end");
        end
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h5555_5555 || bus.out_len !== CW'(32) || bus.out_ones !== CW'(16)) begin
            n_bad++;
            $display("FAIL full_word: valid=%b data=%h len=%0d ones=%0d, required 1 55555555 32 16",
                     bus.out_valid, bus.out_data, bus.out_len, bus.out_ones);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL full_one_cycle: out_valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_bit    = 1'b1;
            bus.flush     = 1'b0;
            bus.out_ready = 1'b0;
            #1;
            if (bus.in_ready === 1'b1) acc++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (acc != 2 * WIDTH) begin
            n_bad++;
            $display("FAIL bp_accepts: accepted=%0d, required %0d", acc, 2 * WIDTH);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFF_FFFF || bus.out_len !== CW'(32)) begin
            n_bad++;
            $display("FAIL bp_hold: in_ready=%b valid=%b data=%h len=%0d, required 0 1 ffffffff 32",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_len);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL bp_stall: in_ready=%b valid=%b data=%h, required 0 1 ffffffff", bus.in_ready, bus.out_valid, bus.out_data);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFF_FFFF || bus.out_ones !== CW'(32)) begin
            n_bad++;
            $display("FAIL bp_first_hs: in_ready=%b valid=%b data=%h ones=%0d, required 1 1 ffffffff 32",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_ones);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_second_hs: out_valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        logic [4:0] pat = 5'b11011;
        for (int i = 0; i < 5; i++) drive(1'b1, pat[i], 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1B || bus.out_len !== CW'(5) || bus.out_ones !== CW'(4)) begin
            n_bad++;
            $display("FAIL flush_word: valid=%b data=%h len=%0d ones=%0d, required 1 1b 5 4",
                     bus.out_valid, bus.out_data, bus.out_len, bus.out_ones);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_empty: out_valid=%b, required 0", bus.out_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h5 || bus.out_len !== CW'(3) || bus.out_ones !== CW'(2)) begin
            n_bad++;
            $display("FAIL flush_with_accept: valid=%b data=%h len=%0d ones=%0d, required 1 5 3 2",
                     bus.out_valid, bus.out_data, bus.out_len, bus.out_ones);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        // Fill the slot with 0x7, then close 0x2 behind it to force HOLD.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_entry: in_ready=%b, required 0", bus.in_ready);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_data !== 32'h7 || bus.out_len !== CW'(3)) begin
            n_bad++;
            $display("FAIL hold_flush_ignored: in_ready=%b data=%h len=%0d, required 0 7 3", bus.in_ready, bus.out_data, bus.out_len);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h2 || bus.out_len !== CW'(2) || bus.out_ones !== CW'(1)) begin
            n_bad++;
            $display("FAIL hold_release: valid=%b data=%h len=%0d ones=%0d, required 1 2 2 1",
                     bus.out_valid, bus.out_data, bus.out_len, bus.out_ones);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (bus.out_data !== 32'h1 || bus.out_len !== CW'(1)) begin
            n_bad++;
            $display("FAIL hold_clean_refill: data=%h len=%0d, required 1 1", bus.out_data, bus.out_len);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_mid_reset();
        bit early = 1'b0;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            if (i < WIDTH - 1 && bus.out_valid !== 1'b0) early = 1'b1;
        end
        n_cmp++;
        if (early || bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFF_FFFF || bus.out_len !== CW'(32)) begin
            n_bad++;
            $display("FAIL reset_mid_word: early=%b valid=%b data=%h len=%0d, required 0 1 ffffffff 32",
                     early, bus.out_valid, bus.out_data, bus.out_len);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_precond_valid: out_valid=%b, required 1", bus.out_valid);
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_len !== '0 || bus.out_ones !== '0 || bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_full_slot: valid=%b data=%h len=%0d ones=%0d in_ready=%b, required 0 0 0 0 0",
                     bus.out_valid, bus.out_data, bus.out_len, bus.out_ones, bus.in_ready);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int hs_start = hs_count;
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && model_bits.size() == 0 && bus.out_valid === 1'b0) break;
            drive(1'b0, 1'b0, 1'b1, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (exp_q.size() != 0 || model_bits.size() != 0 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL random_drain: pending=%0d partial=%0d out_valid=%b, required 0 0 0",
                     exp_q.size(), model_bits.size(), bus.out_valid);
        end
        n_cmp++;
        if (hs_count - hs_start < 10) begin
            n_bad++;
            $display("FAIL random_activity: handshakes=%0d, required >= 10", hs_count - hs_start);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_full_word();
        test_backpressure();
        test_flush();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
